aip_bus_arbiter: RTL

//   Shares one AIP slave port (data_in/data_out/conf_dbus/read/write/start/int_req) between two

---
 rtl/aip_bus_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/aip_bus_arbiter.sv
// Two-master AIP slave-port arbiter: round-robin on ties, grant held for a whole transaction, one dead GAP cycle after release.
// Latency: grant 1 cycle after req; datapath is combinational from the grant. Optional idle-owner watchdog: AIP_ARB_TIMEOUT_EN.
module aip_bus_arbiter #(
    parameter int DATA_W         = 32,
    parameter int CONF_W         = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m1_req,
    output logic              o_m0_gnt,
    output logic              o_m1_gnt,
    input  logic [DATA_W-1:0] i_m0_data_in,
    input  logic [DATA_W-1:0] i_m1_data_in,
    input  logic [CONF_W-1:0] i_m0_conf,
    input  logic [CONF_W-1:0] i_m1_conf,
    input  logic              i_m0_read,
    input  logic              i_m0_write,
    input  logic              i_m0_start,
    input  logic              i_m1_read,
    input  logic              i_m1_write,
    input  logic              i_m1_start,
    output logic [DATA_W-1:0] o_m0_data_out,
    output logic [DATA_W-1:0] o_m1_data_out,
    output logic              o_m0_int,
    output logic              o_m1_int,
    output logic [DATA_W-1:0] o_s_data_in,
    output logic [CONF_W-1:0] o_s_conf,
    output logic              o_s_read,
    output logic              o_s_write,
    output logic              o_s_start,
    input  logic [DATA_W-1:0] i_s_data_out,
    input  logic              i_s_int_req,
    output logic              o_busy,
    output logic              o_timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1, ST_GAP} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_owner;     // 1 = M1 owned last, so M0 wins the next tie
    logic   w_last_owner_nxt;
    logic   w_to_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        unique case (r_state)
            ST_IDLE, ST_GAP: begin
                if (i_m0_req && (!i_m1_req || r_last_owner))
                    w_state_nxt = ST_OWN0;
                else if (i_m1_req)
                    w_state_nxt = ST_OWN1;
                else
                    w_state_nxt = ST_IDLE;
            end
            ST_OWN0: begin
                if (!i_m0_req || w_to_hit) begin
                    w_state_nxt      = ST_GAP;
                    w_last_owner_nxt = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!i_m1_req || w_to_hit) begin
                    w_state_nxt      = ST_GAP;
                    w_last_owner_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_m0_gnt = (r_state == ST_OWN0);
    assign o_m1_gnt = (r_state == ST_OWN1);
    assign o_busy   = o_m0_gnt | o_m1_gnt;

    // Non-owner strobes are simply dropped; nothing is queued.
    assign o_s_data_in   = o_m0_gnt ? i_m0_data_in : (o_m1_gnt ? i_m1_data_in : '0);
    assign o_s_conf      = o_m0_gnt ? i_m0_conf    : (o_m1_gnt ? i_m1_conf    : '0);
    assign o_s_read      = (o_m0_gnt & i_m0_read)  | (o_m1_gnt & i_m1_read);
    assign o_s_write     = (o_m0_gnt & i_m0_write) | (o_m1_gnt & i_m1_write);
    assign o_s_start     = (o_m0_gnt & i_m0_start) | (o_m1_gnt & i_m1_start);
    assign o_m0_data_out = o_m0_gnt ? i_s_data_out : '0;
    assign o_m1_data_out = o_m1_gnt ? i_s_data_out : '0;

    // With no owner the interrupt goes to whoever owned the port last.
    assign o_m0_int = i_s_int_req & (o_m0_gnt | (!o_busy & !r_last_owner));
    assign o_m1_int = i_s_int_req & (o_m1_gnt | (!o_busy &  r_last_owner));

`ifdef AIP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_to_half;
    logic             r_timeout;
    logic             w_own;
    logic             w_owner_strobe;
    logic             w_enter_own;

    assign w_own          = o_busy;
    assign w_owner_strobe = (o_m0_gnt & (i_m0_read | i_m0_write | i_m0_start)) |
                            (o_m1_gnt & (i_m1_read | i_m1_write | i_m1_start));
    assign w_enter_own    = ((w_state_nxt == ST_OWN0) || (w_state_nxt == ST_OWN1)) &&
                            (w_state_nxt != r_state);
    assign w_to_hit       = w_own && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counter advances on every second idle owned cycle and saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt  <= '0;
            r_to_half <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit & ((o_m0_gnt & i_m0_req) | (o_m1_gnt & i_m1_req));
            if (w_enter_own || w_owner_strobe) begin
                r_to_cnt  <= '0;
                r_to_half <= 1'b0;
            end else if (w_own) begin
                r_to_half <= ~r_to_half;
                if (r_to_half && (r_to_cnt != CNT_W'(TIMEOUT_CYCLES)))
                    r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;

    // The idle limit has no effect when the watchdog is not built in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
    end
`endif

endmodule
